// File: rtl/field_scanner_if.sv
// ----------------------------------------------------------------------------
// field_scanner_if
// Handshake/coordinate bundle between a field_scanner and the block that
// starts it and consumes its coordinate stream.
//
// Parameters
//   X_W, Y_W   coordinate widths; must equal $clog2(FIELD_W) / $clog2(FIELD_H)
//              of the attached scanner.
//
// Signals (names seen from the scanner: i_* into it, o_* out of it)
//   i_start    request a scan (honoured only while the scanner is idle)
//   i_dir      0 forward raster, 1 reverse raster, sampled with i_start
//   i_abort    terminate the scan in progress
//   i_ready    consumer accepts the current beat
//   o_valid    o_x/o_y (and o_nb_idx) hold a beat
//   o_x, o_y   beat coordinate
//   o_first    first beat of a scan
//   o_last     final beat of a scan
//   o_busy     scan in progress
//   o_done     one-cycle pulse after the final beat is accepted
//   o_nb_idx   neighbour index 0..8 (only with FIELD_SCANNER_NEIGHBORS_EN)
//
// Modports
//   master  the scanner
//   slave   the requester/consumer
// ----------------------------------------------------------------------------
interface field_scanner_if #(
  parameter int X_W = 5,
  parameter int Y_W = 4
);
  logic           i_start;
  logic           i_dir;
  logic           i_abort;
  logic           i_ready;
  logic           o_valid;
  logic [X_W-1:0] o_x;
  logic [Y_W-1:0] o_y;
  logic           o_first;
  logic           o_last;
  logic           o_busy;
  logic           o_done;
`ifdef FIELD_SCANNER_NEIGHBORS_EN
  logic [3:0]     o_nb_idx;
`endif

  modport master (
    input  i_start, i_dir, i_abort, i_ready,
    output o_valid, o_x, o_y, o_first, o_last, o_busy, o_done
`ifdef FIELD_SCANNER_NEIGHBORS_EN
    , output o_nb_idx
`endif
  );

  modport slave (
    output i_start, i_dir, i_abort, i_ready,
    input  o_valid, o_x, o_y, o_first, o_last, o_busy, o_done
`ifdef FIELD_SCANNER_NEIGHBORS_EN
    , input o_nb_idx
`endif
  );
endinterface

// File: rtl/field_scanner.sv
// ----------------------------------------------------------------------------
// field_scanner
// Walks every cell of a FIELD_W x FIELD_H field in raster order (forward from
// (0,0) or reverse from (FIELD_W-1,FIELD_H-1)) and presents one coordinate per
// beat on a valid/ready stream. A scan can be aborted at any beat.
//
// Optional feature: define FIELD_SCANNER_NEIGHBORS_EN to emit nine beats per
// cell (centre, then its eight toroidally wrapped neighbours) tagged with
// o_nb_idx. Without the macro exactly one beat per cell is emitted.
//
// Ports
//   i_clk     clock, all state changes on the rising edge
//   i_rst_n   asynchronous active-low reset; clears state and all outputs
//   bus       field_scanner_if.master (start/dir/abort/ready in,
//             valid/x/y/first/last/busy/done[/nb_idx] out)
// ----------------------------------------------------------------------------
module field_scanner #(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 15
) (
  input logic             i_clk,
  input logic             i_rst_n,
  field_scanner_if.master bus
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);
  localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Wrapping single steps; fields need not be a power of two, so wrap
  // explicitly at the maximum rather than relying on overflow.
  function automatic logic [X_ADR_SIZE-1:0] x_inc(input logic [X_ADR_SIZE-1:0] x);
    return (x == X_MAX) ? '0 : x + 1'b1;
  endfunction
  function automatic logic [X_ADR_SIZE-1:0] x_dec(input logic [X_ADR_SIZE-1:0] x);
    return (x == '0) ? X_MAX : x - 1'b1;
  endfunction
  function automatic logic [Y_ADR_SIZE-1:0] y_inc(input logic [Y_ADR_SIZE-1:0] y);
    return (y == Y_MAX) ? '0 : y + 1'b1;
  endfunction
  function automatic logic [Y_ADR_SIZE-1:0] y_dec(input logic [Y_ADR_SIZE-1:0] y);
    return (y == '0) ? Y_MAX : y - 1'b1;
  endfunction

  // Final cell of the raster for the latched direction.
  function automatic logic is_end(input logic d,
                                  input logic [X_ADR_SIZE-1:0] x,
                                  input logic [Y_ADR_SIZE-1:0] y);
    return d ? ((x == '0) && (y == '0)) : ((x == X_MAX) && (y == Y_MAX));
  endfunction

  state_t                  state_reg;
  logic                    dir_reg;
  logic [X_ADR_SIZE-1:0]   cell_x_reg, cell_x_next, adv_x;
  logic [Y_ADR_SIZE-1:0]   cell_y_reg, cell_y_next, adv_y;
  logic [X_ADR_SIZE-1:0]   x_reg, x_next;
  logic [Y_ADR_SIZE-1:0]   y_reg, y_next;
  logic                    last_next;
  logic                    valid_reg, first_reg, last_reg, busy_reg, done_reg;

  // Next cell in raster order for the latched direction.
  always_comb begin
    adv_x = cell_x_reg;
    adv_y = cell_y_reg;
    if (!dir_reg) begin
      adv_x = x_inc(cell_x_reg);
      if (cell_x_reg == X_MAX) adv_y = y_inc(cell_y_reg);
    end else begin
      adv_x = x_dec(cell_x_reg);
      if (cell_x_reg == '0) adv_y = y_dec(cell_y_reg);
    end
  end

`ifdef FIELD_SCANNER_NEIGHBORS_EN
  logic [3:0] idx_reg, idx_next;

  // Neighbour offsets: idx 1,4,6 take x-1 and 3,5,8 take x+1;
  // idx 1,2,3 take y-1 and 6,7,8 take y+1; idx 0 is the centre.
  function automatic logic [X_ADR_SIZE-1:0] nb_x(input logic [X_ADR_SIZE-1:0] x,
                                                 input logic [3:0] idx);
    case (idx)
      4'd1, 4'd4, 4'd6: return x_dec(x);
      4'd3, 4'd5, 4'd8: return x_inc(x);
      default:          return x;
    endcase
  endfunction
  function automatic logic [Y_ADR_SIZE-1:0] nb_y(input logic [Y_ADR_SIZE-1:0] y,
                                                 input logic [3:0] idx);
    case (idx)
      4'd1, 4'd2, 4'd3: return y_dec(y);
      4'd6, 4'd7, 4'd8: return y_inc(y);
      default:          return y;
    endcase
  endfunction

  always_comb begin
    cell_x_next = cell_x_reg;
    cell_y_next = cell_y_reg;
    idx_next    = idx_reg + 4'd1;
    if (idx_reg == 4'd8) begin
      cell_x_next = adv_x;
      cell_y_next = adv_y;
      idx_next    = 4'd0;
    end
    x_next    = nb_x(cell_x_next, idx_next);
    y_next    = nb_y(cell_y_next, idx_next);
    last_next = is_end(dir_reg, cell_x_next, cell_y_next) && (idx_next == 4'd8);
  end

  assign bus.o_nb_idx = idx_reg;
`else
  always_comb begin
    cell_x_next = adv_x;
    cell_y_next = adv_y;
    x_next      = adv_x;
    y_next      = adv_y;
    last_next   = is_end(dir_reg, adv_x, adv_y);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      dir_reg    <= 1'b0;
      cell_x_reg <= '0;
      cell_y_reg <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      valid_reg  <= 1'b0;
      first_reg  <= 1'b0;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef FIELD_SCANNER_NEIGHBORS_EN
      idx_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.i_start) begin
            state_reg  <= SCAN;
            dir_reg    <= bus.i_dir;
            cell_x_reg <= bus.i_dir ? X_MAX : '0;
            cell_y_reg <= bus.i_dir ? Y_MAX : '0;
            x_reg      <= bus.i_dir ? X_MAX : '0;
            y_reg      <= bus.i_dir ? Y_MAX : '0;
            valid_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            first_reg  <= 1'b1;
            // Both dimensions are >= 2, so the first beat is never the last.
            last_reg   <= 1'b0;
`ifdef FIELD_SCANNER_NEIGHBORS_EN
            idx_reg    <= 4'd0;
`endif
          end
        end
        SCAN: begin
          // Abort wins over a beat accepted in the same cycle.
          if (bus.i_abort) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
          end else if (valid_reg && bus.i_ready) begin
            if (last_reg) begin
              state_reg <= DONE;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              first_reg <= 1'b0;
              last_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              cell_x_reg <= cell_x_next;
              cell_y_reg <= cell_y_next;
              x_reg      <= x_next;
              y_reg      <= y_next;
              first_reg  <= 1'b0;
              last_reg   <= last_next;
`ifdef FIELD_SCANNER_NEIGHBORS_EN
              idx_reg    <= idx_next;
`endif
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_valid = valid_reg;
  assign bus.o_x     = x_reg;
  assign bus.o_y     = y_reg;
  assign bus.o_first = first_reg;
  assign bus.o_last  = last_reg;
  assign bus.o_busy  = busy_reg;
  assign bus.o_done  = done_reg;
endmodule

// File: tb/tb_field_scanner.sv
// ----------------------------------------------------------------------------
// tb_field_scanner
// Directed self-checking bench for field_scanner at FIELD_W=32, FIELD_H=15.
// Default build: reset, forward/reverse raster, back-pressure, abort and
// mid-scan reset. With FIELD_SCANNER_NEIGHBORS_EN: reset and neighbour scan.
// ----------------------------------------------------------------------------
module tb_field_scanner;
  localparam int W  = 32;
  localparam int H  = 15;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int NBEATS = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  field_scanner_if #(.X_W(XW), .Y_W(YW)) bus ();

  field_scanner #(.FIELD_W(W), .FIELD_H(H)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observed beat: {valid, x, y, first, last}
  logic [XW+YW+2:0] obs, expv;
  logic [2:0]       st_obs;    // {valid, busy, done}

  always_comb obs = {bus.o_valid, bus.o_x, bus.o_y, bus.o_first, bus.o_last};
  always_comb st_obs = {bus.o_valid, bus.o_busy, bus.o_done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_dir = 1'b0; bus.i_abort = 1'b0; bus.i_ready = 1'b1;
    #12;
    n_cmp++;
    if (st_obs !== 3'b000) begin
      n_bad++; $display("FAIL reset_status: got %b want 000", st_obs);
    end
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_beat: got %h want 0", obs);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (st_obs !== 3'b000) begin
      n_bad++; $display("FAIL idle_after_reset: got %b want 000", st_obs);
    end
    $display("test_reset done");
  endtask

`ifndef FIELD_SCANNER_NEIGHBORS_EN
  task automatic test_forward();
    int ex = 0, ey = 0;
    bus.i_dir = 1'b0; bus.i_ready = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int k = 0; k < NBEATS; k++) begin
      expv = {1'b1, XW'(ex), YW'(ey), (k == 0), (k == NBEATS - 1)};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL fwd_beat %0d: got %h want %h", k, obs, expv);
      end
      if (ex == W - 1) begin ex = 0; ey++; end else ex++;
      step();
    end
    // Final beat accepted on the previous edge: done pulse now.
    n_cmp++;
    if (st_obs !== 3'b001) begin
      n_bad++; $display("FAIL fwd_done: got %b want 001", st_obs);
    end
    // A start presented during DONE must be ignored.
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    n_cmp++;
    if (st_obs !== 3'b000) begin
      n_bad++; $display("FAIL start_in_done: got %b want 000", st_obs);
    end
    step();
    n_cmp++;
    if (st_obs !== 3'b000) begin
      n_bad++; $display("FAIL fwd_idle: got %b want 000", st_obs);
    end
    $display("test_forward: %0d beats checked", NBEATS);
  endtask

  task automatic test_reverse();
    int ex = W - 1, ey = H - 1;
    bus.i_dir = 1'b1; bus.i_ready = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0; bus.i_dir = 1'b0;
    for (int k = 0; k < NBEATS; k++) begin
      expv = {1'b1, XW'(ex), YW'(ey), (k == 0), (k == NBEATS - 1)};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL rev_beat %0d: got %h want %h", k, obs, expv);
      end
      if (ex == 0) begin ex = W - 1; ey--; end else ex--;
      step();
    end
    n_cmp++;
    if (st_obs !== 3'b001) begin
      n_bad++; $display("FAIL rev_done: got %b want 001", st_obs);
    end
    step();
    $display("test_reverse: %0d beats checked", NBEATS);
  endtask

  task automatic test_backpressure();
    int ex = 0, ey = 0;
    bus.i_dir = 1'b0; bus.i_ready = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int k = 0; k < NBEATS; k++) begin
      expv = {1'b1, XW'(ex), YW'(ey), (k == 0), (k == NBEATS - 1)};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL bp_beat %0d: got %h want %h", k, obs, expv);
      end
      if (ex == 5 && ey == 3) begin
        bus.i_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          n_cmp++;
          if (obs !== expv) begin
            n_bad++; $display("FAIL bp_hold %0d: got %h want %h", s, obs, expv);
          end
        end
        bus.i_ready = 1'b1;
      end
      if (ex == W - 1) begin ex = 0; ey++; end else ex++;
      step();
    end
    n_cmp++;
    if (st_obs !== 3'b001) begin
      n_bad++; $display("FAIL bp_done: got %b want 001", st_obs);
    end
    step();
    $display("test_backpressure: stall at (5,3) for 5 cycles");
  endtask

  task automatic test_abort();
    int ex = 0, ey = 0;
    bus.i_dir = 1'b0; bus.i_ready = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int k = 0; k <= 10 + 7 * W; k++) begin
      expv = {1'b1, XW'(ex), YW'(ey), (k == 0), 1'b0};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL abort_beat %0d: got %h want %h", k, obs, expv);
      end
      if (ex == 10 && ey == 7) break;
      // Mid-scan start with the opposite direction must change nothing.
      bus.i_start = (k == 50);
      bus.i_dir   = (k >= 50);
      if (ex == W - 1) begin ex = 0; ey++; end else ex++;
      step();
    end
    bus.i_start = 1'b0; bus.i_dir = 1'b0;
    bus.i_abort = 1'b1;                 // with i_ready still high
    step();
    bus.i_abort = 1'b0;
    n_cmp++;
    if (st_obs !== 3'b000) begin
      n_bad++; $display("FAIL abort_drop: got %b want 000", st_obs);
    end
    step();
    n_cmp++;
    if (st_obs !== 3'b000) begin
      n_bad++; $display("FAIL abort_no_done: got %b want 000", st_obs);
    end
    // Abort in IDLE is ignored: the start alongside it is honoured.
    bus.i_start = 1'b1; bus.i_abort = 1'b1;
    step();
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    expv = {1'b1, XW'(0), YW'(0), 1'b1, 1'b0};
    n_cmp++;
    if (obs !== expv) begin
      n_bad++; $display("FAIL abort_restart: got %h want %h", obs, expv);
    end
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    step();
    $display("test_abort: aborted at (10,7), restart from (0,0)");
  endtask

  task automatic test_reset_mid();
    int ex = 0, ey = 0;
    bus.i_dir = 1'b0; bus.i_ready = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int k = 0; k <= 20 + 9 * W; k++) begin
      if (ex == 20 && ey == 9) break;
      if (ex == W - 1) begin ex = 0; ey++; end else ex++;
      step();
    end
    expv = {1'b1, XW'(20), YW'(9), 1'b0, 1'b0};
    n_cmp++;
    if (obs !== expv) begin
      n_bad++; $display("FAIL rst_pre: got %h want %h", obs, expv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({st_obs, obs} !== '0) begin
      n_bad++; $display("FAIL rst_async: got %h want 0", {st_obs, obs});
    end
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++;
      if (st_obs !== 3'b000) begin
        n_bad++; $display("FAIL rst_no_done %0d: got %b want 000", s, st_obs);
      end
    end
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    expv = {1'b1, XW'(0), YW'(0), 1'b1, 1'b0};
    n_cmp++;
    if (obs !== expv) begin
      n_bad++; $display("FAIL rst_restart: got %h want %h", obs, expv);
    end
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    step();
    $display("test_reset_mid: reset at (20,9)");
  endtask
`else
  task automatic test_neighbors();
    int tbl_x [9] = '{0, 31, 0, 1, 31, 1, 31, 0, 1};
    int tbl_y [9] = '{0, 14, 14, 14, 0, 0, 1, 1, 1};
    int dxs [9] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
    int dys [9] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
    int cx = 0, cy = 0, idx = 0, ex, ey;
    logic [3:0] nb_exp;
    bus.i_dir = 1'b0; bus.i_ready = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int k = 0; k < 9 * NBEATS; k++) begin
      if (k < 9) begin
        ex = tbl_x[k]; ey = tbl_y[k];
      end else begin
        ex = (cx + dxs[idx] + W) % W;
        ey = (cy + dys[idx] + H) % H;
      end
      nb_exp = 4'(idx);
      expv = {1'b1, XW'(ex), YW'(ey), (k == 0), (k == 9 * NBEATS - 1)};
      n_cmp++;
      if (obs !== expv || bus.o_nb_idx !== nb_exp) begin
        n_bad++;
        $display("FAIL nb_beat %0d: got %h idx %0d want %h idx %0d",
                 k, obs, bus.o_nb_idx, expv, nb_exp);
      end
      if (idx == 8) begin
        idx = 0;
        if (cx == W - 1) begin cx = 0; cy++; end else cx++;
      end else idx++;
      step();
    end
    n_cmp++;
    if (st_obs !== 3'b001) begin
      n_bad++; $display("FAIL nb_done: got %b want 001", st_obs);
    end
    step();
    $display("test_neighbors: %0d beats checked", 9 * NBEATS);
  endtask
`endif

  initial begin
    test_reset();
`ifndef FIELD_SCANNER_NEIGHBORS_EN
    test_forward();
    test_reverse();
    test_backpressure();
    test_abort();
    test_reset_mid();
`else
    test_neighbors();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/field_scanner.md
FIELD_SCANNER -- requirements
Module: field_scanner

Interface
REQ-001 SHALL have parameter FIELD_W, default 32, field width in cells (>= 2, any value, not only powers of two).
REQ-002 SHALL have parameter FIELD_H, default 15, field height in cells (>= 2, any value).
REQ-003 SHALL define X_ADR_SIZE = $clog2(FIELD_W) and Y_ADR_SIZE = $clog2(FIELD_H) as localparams.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  request to begin a scan; honoured only in IDLE.
REQ-007 SHALL have port i_dir  input  1  scan direction, 0 forward raster, 1 reverse raster; sampled with i_start.
REQ-008 SHALL have port i_abort  input  1  terminates the scan in progress.
REQ-009 SHALL have port i_ready  input  1  consumer accepts the current beat.
REQ-010 SHALL have port o_valid  output  1  o_x/o_y (and o_nb_idx) are valid.
REQ-011 SHALL have port o_x  output  X_ADR_SIZE  current x coordinate.
REQ-012 SHALL have port o_y  output  Y_ADR_SIZE  current y coordinate.
REQ-013 SHALL have port o_first / o_last  output  1 each  marks the first / final beat of a scan.
REQ-014 SHALL have port o_busy  output  1  high in SCAN state.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on i_start; SCAN->DONE on acceptance of the o_last beat; DONE->IDLE unconditionally after one cycle; SCAN->IDLE on i_abort.
REQ-017 SHALL assert o_valid in the cycle after i_start is sampled in IDLE, with first coordinate (0,0) if i_dir=0, (FIELD_W-1,FIELD_H-1) if i_dir=1.
REQ-018 SHALL advance a beat only on o_valid && i_ready; the next beat is presented the following cycle; throughput one beat per cycle with i_ready held high.
REQ-019 SHALL hold o_x, o_y, o_nb_idx, o_first, o_last stable while o_valid && !i_ready.
REQ-020 SHALL advance forward as x+1, wrapping x from FIELD_W-1 to 0 with y+1; reverse as x-1, wrapping x from 0 to FIELD_W-1 with y-1; no out-of-range coordinate ever output.
REQ-021 SHALL assert o_last on (FIELD_W-1,FIELD_H-1) forward and on (0,0) reverse (on its final neighbour beat when SCAN_NEIGHBORS_EN is defined).
REQ-022 SHALL ignore i_start in SCAN and DONE; i_dir changes mid-scan SHALL have no effect.
REQ-023 SHALL, on i_abort in SCAN, drop o_valid and o_busy next cycle and return to IDLE without o_done; i_abort has priority over a simultaneous accept; i_abort outside SCAN is ignored.
REQ-024 SHALL drive o_valid=0 in IDLE and DONE; o_done=1 only in DONE.

Reset
REQ-025 SHALL, while i_rst_n=0, force state IDLE and all outputs to 0 (o_x=0, o_y=0, o_nb_idx=0) asynchronously.
REQ-026 SHALL, on reset mid-scan, discard the scan; no o_done; a new i_start after release begins from the start coordinate.

Configuration
REQ-027 SHALL, when macro FIELD_SCANNER_NEIGHBORS_EN is defined, add output o_nb_idx (4 bits) and emit 9 beats per cell: idx 0 centre, 1..8 offsets (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1), toroidal wrap on both axes, advancing to the next cell after idx 8.
REQ-028 SHALL, without the macro, omit o_nb_idx and emit exactly one beat per cell.

Verification (FIELD_W=32, FIELD_H=15)
REQ-029 SHALL cover: macro off, i_dir=0, i_ready=1, pulse i_start -> 480 beats (0,0),(1,0)..(31,0),(0,1)..(31,14); o_first on (0,0), o_last on (31,14); o_done in cycle 482 after start.
REQ-030 SHALL cover: i_dir=1 -> first beat (31,14), then (30,14)..(0,14),(31,13).., last (0,0) with o_last.
REQ-031 SHALL cover: i_ready=0 for 5 cycles while presenting (5,3) -> outputs frozen at (5,3), then (6,3), no beat skipped or duplicated.
REQ-032 SHALL cover: i_abort while presenting (10,7) -> o_valid=0, o_busy=0 next cycle, no o_done; new i_start -> (0,0); i_start mid-scan ignored.
REQ-033 SHALL cover: macro on, cell (0,0) -> (0,0),(31,14),(0,14),(1,14),(31,0),(1,0),(31,1),(0,1),(1,1) with o_nb_idx 0..8; total 4320 beats per scan.
REQ-034 SHALL cover: i_rst_n low at (20,9) -> all outputs 0 immediately, state IDLE, no o_done after release.
